// File: rtl/syn_pkg.sv
// Shared constants, config FSM state type and reset-weight helper
// for the synaptic integrator and its weight bank.
package syn_pkg;

    localparam int N_IN_DEF        = 4;
    localparam int WW_DEF          = 6;
    localparam int DECAY_SHIFT_DEF = 1;
    localparam int REFRAC_CYC_DEF  = 3;

    // Reset weights: first three lines excitatory, fourth inhibitory.
    localparam int W_RST_POS = 4;
    localparam int W_RST_NEG = -4;

    // Output clamp limits for the 8-bit current.
    localparam int CUR_MIN = 0;
    localparam int CUR_MAX = 255;

    typedef enum logic {
        CFG_IDLE   = 1'b0,
        CFG_COMMIT = 1'b1
    } cfg_state_e;

    function automatic int syn_rst_weight(input int idx);
        if (idx < 3) begin
            return W_RST_POS;
        end else if (idx == 3) begin
            return W_RST_NEG;
        end
        return 0;
    endfunction

endpackage

// File: rtl/syn_weight_bank.sv
// Shadow and active weight registers with atomic one-cycle commit.
// Writes land in shadow; the active bank only changes as a whole.
module syn_weight_bank
    import syn_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int WW   = WW_DEF,
    parameter int AW   = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we_i,
    input  logic [AW-1:0]     cfg_addr_i,
    input  logic [WW-1:0]     cfg_data_i,
    input  logic              cfg_commit_i,
    output logic              cfg_busy_o,
    output logic [N_IN*WW-1:0] w_active_o
);

    cfg_state_e state_q;
    cfg_state_e state_d;

    logic shadow_we;
    logic active_ld;

    logic [WW-1:0] shadow_q [N_IN];
    logic [WW-1:0] active_q [N_IN];

    // Config FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CFG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Config FSM next state: COMMIT always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CFG_IDLE:   if (cfg_commit_i) state_d = CFG_COMMIT;
            CFG_COMMIT: state_d = CFG_IDLE;
            default:    state_d = CFG_IDLE;
        endcase
    end

    // Config FSM outputs: writes only accepted in IDLE
    always_comb begin
        cfg_busy_o = 1'b0;
        shadow_we  = 1'b0;
        active_ld  = 1'b0;
        unique case (state_q)
            CFG_IDLE: begin
                shadow_we = cfg_we_i;
            end
            CFG_COMMIT: begin
                cfg_busy_o = 1'b1;
                active_ld  = 1'b1;
            end
            default: begin
                cfg_busy_o = 1'b0;
            end
        endcase
    end

    // Shadow bank: single-entry writes from the config port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                shadow_q[i] <= WW'(syn_rst_weight(i));
            end
        end else if (shadow_we) begin
            shadow_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    // Active bank: whole-bank copy at the end of the COMMIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                active_q[i] <= WW'(syn_rst_weight(i));
            end
        end else if (active_ld) begin
            for (int i = 0; i < N_IN; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_flat
        assign w_active_o[g*WW +: WW] = active_q[g];
    end

endmodule

// File: rtl/syn_integrator.sv
// Synaptic integrator: decaying current plus weighted spike sum, clamped.
// Optional refractory gating enabled by defining SYN_REFRACTORY_EN.
module syn_integrator
    import syn_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int WW          = WW_DEF,
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEF,
    parameter int REFRAC_CYC  = REFRAC_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         spike_in,
    input  logic                    spike_fb,
    input  logic                    cfg_we,
    input  logic [$clog2(N_IN)-1:0] cfg_addr,
    input  logic [WW-1:0]           cfg_data,
    input  logic                    cfg_commit,
    output logic                    cfg_busy,
    output logic [7:0]              current,
    output logic                    sat,
    output logic                    refrac
);

    localparam int AW = $clog2(N_IN);
    // Wide enough for 255 plus N_IN worst-case weights of either sign.
    localparam int SW = 8 + WW + AW + 1;

    localparam logic signed [SW-1:0] MIN_S = SW'(CUR_MIN);
    localparam logic signed [SW-1:0] MAX_S = SW'(CUR_MAX);

    logic [N_IN*WW-1:0] w_active;
    logic [N_IN-1:0]    spk_eff;

    logic [7:0] current_q;
    logic [7:0] current_d;
    logic       sat_q;
    logic       sat_d;

    logic [7:0]          decayed;
    logic signed [SW-1:0] acc;

    syn_weight_bank #(
        .N_IN (N_IN),
        .WW   (WW),
        .AW   (AW)
    ) u_bank (
        .clk          (clk),
        .rst          (rst),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_data_i   (cfg_data),
        .cfg_commit_i (cfg_commit),
        .cfg_busy_o   (cfg_busy),
        .w_active_o   (w_active)
    );

`ifdef SYN_REFRACTORY_EN
    localparam int CW = $clog2(REFRAC_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Refractory counter: feedback spike (re)loads, otherwise count down
    always_comb begin
        cnt_d = cnt_q;
        if (spike_fb) begin
            cnt_d = CW'(REFRAC_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Refractory counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign refrac  = (cnt_q != '0);
    assign spk_eff = refrac ? '0 : spike_in;
`else
    logic unused_fb;

    assign unused_fb = spike_fb;
    assign refrac    = 1'b0;
    assign spk_eff   = spike_in;
`endif

    // Integrate: decay the current, add active weights, clamp to 0..255
    always_comb begin
        decayed   = current_q - (current_q >> DECAY_SHIFT);
        acc       = $signed({{(SW-8){1'b0}}, decayed});
        for (int i = 0; i < N_IN; i++) begin
            if (spk_eff[i]) begin
                acc = acc + $signed({{(SW-WW){w_active[i*WW+WW-1]}},
                                     w_active[i*WW +: WW]});
            end
        end
        current_d = acc[7:0];
        sat_d     = 1'b0;
        if (acc < MIN_S) begin
            current_d = 8'(CUR_MIN);
            sat_d     = 1'b1;
        end else if (acc > MAX_S) begin
            current_d = 8'(CUR_MAX);
            sat_d     = 1'b1;
        end
    end

    // Output registers for current and saturation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            current_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            current_q <= current_d;
            sat_q     <= sat_d;
        end
    end

    assign current = current_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_syn_integrator.sv
// Directed bench for syn_integrator (DECAY_SHIFT 1 and 4 instances).
// Refractory expectations follow whether SYN_REFRACTORY_EN is defined.
module tb_syn_integrator;

    logic       clk;
    logic       rst;
    logic [3:0] spike_in;
    logic       spike_fb;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [5:0] cfg_data;
    logic       cfg_commit;

    logic       busy1, sat1, ref1;
    logic [7:0] cur1;
    logic       busy4, sat4, ref4;
    logic [7:0] cur4;

    int checks = 0;
    int errs   = 0;

    int exp_t1  [5]  = '{4, 6, 7, 8, 8};
    int exp_t3c [4]  = '{124, 241, 255, 255};
    int exp_t3s [4]  = '{0, 0, 1, 1};
    int fb_pat  [14] = '{1,0,0,0,0,0,0,1,0,1,0,0,0,0};
`ifdef SYN_REFRACTORY_EN
    int exp_rc  [14] = '{8,4,2,1,5,7,8,8,4,2,1,1,1,5};
    int exp_rr  [14] = '{1,1,1,0,0,0,0,1,1,1,1,1,0,0};
`else
    int exp_rc  [14] = '{8,8,8,8,8,8,8,8,8,8,8,8,8,8};
    int exp_rr  [14] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0};
`endif

    syn_integrator #(.DECAY_SHIFT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .spike_fb   (spike_fb),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_busy   (busy1),
        .current    (cur1),
        .sat        (sat1),
        .refrac     (ref1)
    );

    syn_integrator #(.DECAY_SHIFT(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .spike_fb   (spike_fb),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_busy   (busy4),
        .current    (cur4),
        .sat        (sat4),
        .refrac     (ref4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        spike_in   = '0;
        spike_fb   = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_commit = 1'b0;
        tick();
        tick();
        chk("rst_cur",   32'(cur1),  0);
        chk("rst_sat",   32'(sat1),  0);
        chk("rst_busy",  32'(busy1), 0);
        chk("rst_refrac", 32'(ref1), 0);
        rst = 1'b0;

        // Single excitatory line held: converge to 8
        spike_in = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("ramp_cur%0d", k), 32'(cur1), 32'(exp_t1[k]));
            chk($sformatf("ramp_sat%0d", k), 32'(sat1), 0);
        end

        // Inhibitory line from zero: clamps low
        spike_in = 4'b0000;
        do_reset();
        spike_in = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("neg_cur%0d", k), 32'(cur1), 0);
            chk($sformatf("neg_sat%0d", k), 32'(sat1), 1);
        end

        // Slow-decay instance, all weights +31: clamps high
        spike_in = 4'b0000;
        do_reset();
        cfg_we   = 1'b1;
        cfg_data = 6'd31;
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            tick();
        end
        cfg_we     = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("hi_busy", 32'(busy4), 1);
        tick();
        spike_in = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("hi_cur%0d", k), 32'(cur4), 32'(exp_t3c[k]));
            chk($sformatf("hi_sat%0d", k), 32'(sat4), 32'(exp_t3s[k]));
        end

        // Shadow write, commit, dropped write during busy, same-cycle we+commit
        spike_in = 4'b0000;
        do_reset();
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 6'd10;
        tick();
        cfg_we   = 1'b0;
        spike_in = 4'b0001;
        tick();
        chk("shadow_only", 32'(cur1), 4);
        spike_in   = 4'b0000;
        cfg_commit = 1'b1;
        tick();
        chk("commit_busy", 32'(busy1), 1);
        chk("commit_cur",  32'(cur1),  2);
        cfg_commit = 1'b0;
        cfg_we     = 1'b1;
        cfg_addr   = 2'd1;
        cfg_data   = 6'd20;
        tick();
        chk("commit_done", 32'(busy1), 0);
        chk("decay_1",     32'(cur1),  1);
        cfg_we   = 1'b0;
        spike_in = 4'b0001;
        tick();
        chk("new_w0", 32'(cur1), 11);
        spike_in   = 4'b0000;
        cfg_commit = 1'b1;
        tick();
        chk("c2_cur", 32'(cur1), 6);
        cfg_commit = 1'b0;
        tick();
        chk("c2_dec", 32'(cur1), 3);
        spike_in = 4'b0010;
        tick();
        chk("busy_wr_drop", 32'(cur1), 6);
        spike_in   = 4'b0000;
        cfg_we     = 1'b1;
        cfg_addr   = 2'd2;
        cfg_data   = 6'h38;
        cfg_commit = 1'b1;
        tick();
        chk("wc_busy", 32'(busy1), 1);
        chk("wc_cur",  32'(cur1),  3);
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        tick();
        chk("wc_dec", 32'(cur1), 2);
        spike_in = 4'b0100;
        tick();
        chk("wc_w2_cur", 32'(cur1), 0);
        chk("wc_w2_sat", 32'(sat1), 1);

        // Reset during COMMIT aborts it
        spike_in = 4'b0000;
        do_reset();
        spike_in = 4'b0001;
        tick();
        chk("ra_pre", 32'(cur1), 4);
        spike_in   = 4'b0000;
        cfg_we     = 1'b1;
        cfg_addr   = 2'd0;
        cfg_data   = 6'h30;
        cfg_commit = 1'b1;
        tick();
        chk("ra_busy", 32'(busy1), 1);
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        rst        = 1'b1;
        tick();
        chk("ra_busy0", 32'(busy1), 0);
        chk("ra_cur0",  32'(cur1),  0);
        chk("ra_sat0",  32'(sat1),  0);
        rst      = 1'b0;
        spike_in = 4'b0001;
        tick();
        chk("ra_defw", 32'(cur1), 4);

        // Refractory window (or its absence)
        spike_in = 4'b0000;
        do_reset();
        spike_in = 4'b0001;
        for (int k = 0; k < 5; k++) tick();
        chk("rf_steady", 32'(cur1), 8);
        for (int k = 0; k < 14; k++) begin
            spike_fb = fb_pat[k][0];
            tick();
            chk($sformatf("rf_cur%0d", k), 32'(cur1), 32'(exp_rc[k]));
            chk($sformatf("rf_ref%0d", k), 32'(ref1), 32'(exp_rr[k]));
        end
        spike_fb = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
